// File: rtl/fft_peak_detector.sv
// fft_peak_detector: sits on the FFT output stream, squares the magnitude of
// every bin, tracks the strongest bin inside [MIN_BIN, MAX_BIN] and reports
// the winner once per frame, together with threshold and framing flags.
module fft_peak_detector #(
    parameter int          FFT_LEN    = 1024,
    parameter int          MIN_BIN    = 1,
    parameter int          MAX_BIN    = 511,
    parameter logic [32:0] MAG_THRESH = 33'd4096
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [31:0]                fft_data_in,
    input  logic                       fft_valid_in,
    input  logic                       fft_last_in,
    output logic                       fft_ready_out,
    output logic [$clog2(FFT_LEN)-1:0] peak_bin_out,
    output logic [32:0]                peak_mag_out,
    output logic                       peak_valid_out,
    output logic                       above_thresh_out,
    output logic                       frame_err_out
);

    localparam int BW = $clog2(FFT_LEN);
    localparam logic [BW-1:0] LAST_TAG = BW'(FFT_LEN - 1);
    localparam logic [BW-1:0] MIN_TAG  = BW'(MIN_BIN);
    localparam logic [BW-1:0] MAX_TAG  = BW'(MAX_BIN);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Input side
    logic          accept;
    logic          tag_is_last;
    logic          eof;
    logic          err_set;
    logic [BW-1:0] bin_cnt_q, bin_cnt_d;
    logic          err_q, err_d;

    // Magnitude pipeline; vld_pipe_q[0] qualifies S1, vld_pipe_q[1] qualifies S2
    logic [1:0]        vld_pipe_q;
    logic signed [15:0] re_s, im_s;
    logic signed [31:0] re_sq, im_sq;
    logic [31:0]       s1_re2_q, s1_im2_q;
    logic [BW-1:0]     s1_tag_q, s2_tag_q;
    logic              s1_eof_q, s2_eof_q;
    logic [32:0]       s2_sum_q;

    // Running maximum
    logic              in_win;
    logic              upd;
    logic [32:0]       cmp_mag;
    logic [BW-1:0]     cmp_bin;
    logic [32:0]       max_mag_q, max_mag_d;
    logic [BW-1:0]     max_bin_q, max_bin_d;
    logic              drain_done;

    // Held report
    logic [BW-1:0]     rpt_bin_q, rpt_bin_d;
    logic [32:0]       rpt_mag_q, rpt_mag_d;
    logic              rpt_th_q, rpt_th_d;
    logic              rpt_err_q, rpt_err_d;
    logic              rpt_vld_q, rpt_vld_d;

    // ------------------------------------------------------------------
    // Beat acceptance and frame boundary detection
    // ------------------------------------------------------------------
    assign accept      = fft_valid_in && fft_ready_out;
    assign tag_is_last = (bin_cnt_q == LAST_TAG);
    // Frame closes on tlast or on the final bin, whichever arrives first.
    assign eof         = accept && (fft_last_in || tag_is_last);
    // A mismatch between tlast and the final bin position is a framing error.
    assign err_set     = accept && (fft_last_in != tag_is_last);

    // FSM next state and stream handshake
    always_comb begin
        state_d       = state_q;
        fft_ready_out = 1'b0;
        unique case (state_q)
            COLLECT: begin
                fft_ready_out = 1'b1;
                if (fft_valid_in && (fft_last_in || tag_is_last))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_done)
                    state_d = REPORT;
            end
            REPORT: begin
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) state_q <= COLLECT;
        else         state_q <= state_d;
    end

    // Bin counter and framing error latch next-state
    always_comb begin
        bin_cnt_d = bin_cnt_q;
        err_d     = err_q | err_set;
        if (state_q == REPORT) begin
            bin_cnt_d = '0;
            err_d     = 1'b0;
        end else if (accept) begin
            bin_cnt_d = eof ? '0 : bin_cnt_q + BW'(1);
        end
    end

    // Bin counter and framing error latch registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bin_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            bin_cnt_q <= bin_cnt_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Squared magnitude: signed 16x16 squares are never negative and the
    // worst case (-32768)^2 = 2^30 fits an unsigned 32-bit product.
    // ------------------------------------------------------------------
    assign re_s  = fft_data_in[31:16];
    assign im_s  = fft_data_in[15:0];
    assign re_sq = re_s * re_s;
    assign im_sq = im_s * im_s;

    // Pipeline valid shift register
    always_ff @(posedge clk_in) begin
        if (!rst_in) vld_pipe_q <= '0;
        else         vld_pipe_q <= {vld_pipe_q[0], accept};
    end

    // Pipeline datapath; contents are only meaningful alongside vld_pipe_q
    always_ff @(posedge clk_in) begin
        s1_re2_q <= unsigned'(re_sq);
        s1_im2_q <= unsigned'(im_sq);
        s1_tag_q <= bin_cnt_q;
        s1_eof_q <= eof;
        s2_sum_q <= {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
        s2_tag_q <= s1_tag_q;
        s2_eof_q <= s1_eof_q;
    end

    // ------------------------------------------------------------------
    // Compare stage: strict greater-than so ties keep the earlier bin.
    // ------------------------------------------------------------------
    assign in_win  = (s2_tag_q >= MIN_TAG) && (s2_tag_q <= MAX_TAG);
    assign upd     = vld_pipe_q[1] && in_win && (s2_sum_q > max_mag_q);
    assign cmp_mag = upd ? s2_sum_q : max_mag_q;
    assign cmp_bin = upd ? s2_tag_q : max_bin_q;
    // The end-of-frame beat reaches the compare stage exactly two cycles
    // after acceptance, which ends the drain window.
    assign drain_done = (state_q == DRAIN) && vld_pipe_q[1] && s2_eof_q;

    // Running max next-state, cleared once the report has been issued
    always_comb begin
        max_mag_d = cmp_mag;
        max_bin_d = cmp_bin;
        if (state_q == REPORT) begin
            max_mag_d = '0;
            max_bin_d = '0;
        end
    end

    // Running max registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            max_mag_q <= '0;
            max_bin_q <= '0;
        end else begin
            max_mag_q <= max_mag_d;
            max_bin_q <= max_bin_d;
        end
    end

    // Report capture: loaded from the final compare result so the outputs
    // are valid during the REPORT cycle, then held until the next frame.
    always_comb begin
        rpt_bin_d = rpt_bin_q;
        rpt_mag_d = rpt_mag_q;
        rpt_th_d  = rpt_th_q;
        rpt_err_d = rpt_err_q;
        rpt_vld_d = 1'b0;
        if (drain_done) begin
            rpt_bin_d = cmp_bin;
            rpt_mag_d = cmp_mag;
            rpt_th_d  = (cmp_mag >= MAG_THRESH);
            rpt_err_d = err_q;
            rpt_vld_d = 1'b1;
        end
    end

    // Report registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rpt_bin_q <= '0;
            rpt_mag_q <= '0;
            rpt_th_q  <= 1'b0;
            rpt_err_q <= 1'b0;
            rpt_vld_q <= 1'b0;
        end else begin
            rpt_bin_q <= rpt_bin_d;
            rpt_mag_q <= rpt_mag_d;
            rpt_th_q  <= rpt_th_d;
            rpt_err_q <= rpt_err_d;
            rpt_vld_q <= rpt_vld_d;
        end
    end

    assign peak_bin_out     = rpt_bin_q;
    assign peak_mag_out     = rpt_mag_q;
    assign above_thresh_out = rpt_th_q;
    assign frame_err_out    = rpt_err_q;
    assign peak_valid_out   = rpt_vld_q;

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- Streaming stage directly downstream of the 1024-point FFT core output (AXI-Stream master side).
- Consumes one frame of complex bins and computes the squared magnitude of each bin.
- Tracks the strongest bin inside a configurable search window.
- At end of frame, reports peak bin index, peak magnitude and frame-integrity flags to the tone-identification logic.

Parameters:
- FFT_LEN, 1024: bins per frame; power of two.
- MIN_BIN, 1: lowest bin index searched (skips DC).
- MAX_BIN, 511: highest bin index searched (positive-frequency half only).
- MAG_THRESH, 33'd4096: minimum peak magnitude for above_thresh_out.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- fft_data_in  input  32  [31:16] real, [15:0] imaginary; both signed two's complement
- fft_valid_in  input  1  AXI-S tvalid from FFT
- fft_last_in  input  1  AXI-S tlast from FFT
- fft_ready_out  output  1  AXI-S tready to FFT
- peak_bin_out  output  $clog2(FFT_LEN)  index of strongest bin
- peak_mag_out  output  33  re^2+im^2 of strongest bin, unsigned
- peak_valid_out  output  1  single-cycle pulse; outputs above are valid this cycle and held until the next report
- above_thresh_out  output  1  peak_mag_out >= MAG_THRESH; held with report
- frame_err_out  output  1  frame length was not FFT_LEN; held with report

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - State goes to COLLECT; bin counter 0; running max 0/0.
  - Pipeline valids are cleared.
  - peak_bin_out=0, peak_mag_out=0, peak_valid_out=0, above_thresh_out=0, frame_err_out=0.
  - fft_ready_out=1 from the first cycle after reset.
  - Reset mid-frame discards the partial frame; no report is issued for it.
- Beat acceptance: a beat transfers when fft_valid_in && fft_ready_out.
  - The bin counter tags each accepted beat, then increments.
  - The counter wraps to 0 at end of frame.
- Magnitude pipeline, 2 stages:
  - S1 registers re*re and im*im as unsigned 32-bit products (signed 16x16).
  - S2 registers their 33-bit sum, the bin tag and the last flag.
  - -32768^2 handled exactly: 2^30 per product, no overflow.
- Compare stage, on S2 valid:
  - If MIN_BIN <= tag <= MAX_BIN and sum > running max (strict), update max magnitude and max bin.
  - Ties keep the lower bin.
  - Bins outside the window never update.
- End of frame: the accepted beat with fft_last_in=1, or the beat whose tag==FFT_LEN-1, whichever comes first.
  - frame_err is latched when last arrives with tag != FFT_LEN-1.
  - frame_err is also latched when tag==FFT_LEN-1 arrives without last; that frame is closed and the next beat starts a new frame.
- State machine:
  - COLLECT: fft_ready_out=1. On the end-of-frame beat, go to DRAIN.
  - DRAIN: fft_ready_out=0; wait exactly 2 cycles for the pipeline to empty. Then go to REPORT.
  - REPORT: fft_ready_out=0, for one cycle.
    - Drive peak_bin_out, peak_mag_out, above_thresh_out and frame_err_out from the running max and the frame_err latch.
    - peak_valid_out=1.
    - Clear running max, frame_err latch and bin counter; return to COLLECT.
- Latency: peak_valid_out asserts 3 cycles after the end-of-frame beat is accepted. fft_ready_out is low for 3 cycles per frame.
- No valid in-window bin (all magnitudes zero): report bin 0, magnitude 0, above_thresh 0.
- fft_valid_in gaps (tvalid low) mid-frame: the counter holds and the pipeline bubbles; results are unaffected.
- fft_last_in is ignored when the beat is not accepted.
- Report outputs do not change outside the REPORT cycle except on reset.

Test Plan:
- Single tone:
  - Stimulus: 1024 beats, all zero except bin 100 = {16'd300,16'd400}, tlast on beat 1023.
  - Required: peak_valid_out exactly 3 cycles after the last beat; peak_bin_out=100, peak_mag_out=250000, above_thresh_out=1, frame_err_out=0.
- Tie and window:
  - Stimulus: bin 0 = {16'h7FFF,0}, bins 50 and 60 = {16'd100,0}, bin 700 = {16'd1000,0}.
  - Required: peak_bin_out=50, peak_mag_out=10000 (DC and out-of-window bins ignored; lower bin wins the tie).
- Extremes and threshold:
  - Stimulus: bin 200 = {16'h8000,16'h8000}.
  - Required: peak_mag_out=33'h0_8000_0000, above_thresh_out=1.
  - Stimulus: next frame with only bin 5 = {16'd10,16'd10}.
  - Required: peak_mag_out=200, above_thresh_out=0.
- Framing errors:
  - Stimulus: tlast on beat 511.
  - Required: report after that beat with frame_err_out=1; the next frame restarts at bin 0.
  - Stimulus: a frame of 1024 beats with no tlast.
  - Required: report with frame_err_out=1.
- Backpressure and gaps:
  - Stimulus: random tvalid low gaps inside a frame.
  - Required: result identical to the gap-free run.
  - Required: fft_ready_out=0 for exactly the 3 cycles after the last beat; beats offered during those cycles are not consumed.
- Reset mid-frame:
  - Stimulus: rst_in=0 for 1 cycle at beat 400 of a frame containing a large bin 100.
  - Required: no peak_valid_out pulse and all report outputs at 0.
  - Stimulus: next full frame with its peak at bin 30.
  - Required: report shows bin 30.
